// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between multicycle_ctrl (master) and the datapath (slave).
// The Illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
    logic [5:0] Instr_op;
    logic [5:0] Instr_func;
    logic       ALU_Zero;
    logic       Mem_Ready;
    logic       IR_LdEn;
    logic       PC_LdEn;
    logic       PC_sel;
    logic       RF_WrEn;
    logic       RF_WrData_sel;
    logic       RF_B_sel;
    logic [1:0] ImmExt;
    logic       ALU_Bin_Sel;
    logic [3:0] ALU_func;
    logic       Mem_Rd;
    logic       Mem_WrEn;
    logic       ByteOp;
    logic       Mem_Err;
    logic       Busy;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       Illegal;
`endif

    modport master (
        input  Instr_op, Instr_func, ALU_Zero, Mem_Ready,
        output IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
        output ImmExt, ALU_Bin_Sel, ALU_func, Mem_Rd, Mem_WrEn, ByteOp,
        output Mem_Err, Busy
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output Illegal
`endif
    );

    modport slave (
        output Instr_op, Instr_func, ALU_Zero, Mem_Ready,
        input  IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
        input  ImmExt, ALU_Bin_Sel, ALU_func, Mem_Rd, Mem_WrEn, ByteOp,
        input  Mem_Err, Busy
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input Illegal
`endif
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle CPU datapath; CTRL_ILLEGAL_TRAP_EN turns illegal opcodes into a HALT trap.
// Latency: R/imm 4 cycles, branch 3, load/store 3 + memory cycles + 1.
// Backpressure: stalls in MEM_RD/MEM_WR until Mem_Ready, aborting after MEM_TIMEOUT cycles.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    multicycle_ctrl_if.master ctrl
);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [1:0] BK_B    = 2'd0;
    localparam logic [1:0] BK_BEQ  = 2'd1;
    localparam logic [1:0] BK_BNE  = 2'd2;
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_NEXT, S_BR
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_e;

    typedef enum logic [2:0] {C_R, C_IMM, C_LOAD, C_STORE, C_BR, C_ILL} cls_e;

    typedef struct packed {
        cls_e       cls;
        logic [3:0] alu_func;
        logic [1:0] imm_ext;
        logic       byte_op;
        logic [1:0] br_kind;
    } dec_t;

    typedef struct packed {
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_sel;
        logic       rf_wr;
        logic       rf_wds;
        logic       rfb_sel;
        logic [1:0] imm_ext;
        logic       bin_sel;
        logic [3:0] alu_func;
        logic       mem_rd;
        logic       mem_wr;
        logic       byte_op;
        logic       busy;
    } ctl_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [3:0] alu_r);
        dec_t d;
        d     = '0;
        d.cls = C_ILL;
        case (op)
            6'b100000: begin d.cls = C_R;   d.alu_func = alu_r; end
            6'b110000,
            6'b111000: d.cls = C_IMM;
            6'b110010: begin d.cls = C_IMM; d.alu_func = ALU_AND; d.imm_ext = 2'b01; end
            6'b110011: begin d.cls = C_IMM; d.alu_func = ALU_OR;  d.imm_ext = 2'b01; end
            6'b111001: begin d.cls = C_IMM; d.imm_ext = 2'b10; end
            6'b000011: begin d.cls = C_LOAD;  d.byte_op = 1'b1; end
            6'b001111: d.cls = C_LOAD;
            6'b000111: begin d.cls = C_STORE; d.byte_op = 1'b1; end
            6'b011111: d.cls = C_STORE;
            6'b010000: begin d.cls = C_BR; d.alu_func = ALU_SUB; d.imm_ext = 2'b11; d.br_kind = BK_BEQ; end
            6'b010001: begin d.cls = C_BR; d.alu_func = ALU_SUB; d.imm_ext = 2'b11; d.br_kind = BK_BNE; end
            6'b111111: begin d.cls = C_BR; d.alu_func = ALU_SUB; d.imm_ext = 2'b11; d.br_kind = BK_B;   end
            default: ;
        endcase
        return d;
    endfunction

    state_e          state_q, state_d;
    dec_t            dec_q, dec_d, dec_live;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    ctl_t            ctl;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic            illegal;
`endif

    assign dec_live = decode(ctrl.Instr_op, ctrl.Instr_func[3:0]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_RST;
            dec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dec_d    = dec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ctl      = '0;
        ctl.busy = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal  = 1'b0;
`endif
        case (state_q)
            S_RST: begin
                ctl.busy = 1'b0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                ctl.busy  = 1'b0;
                ctl.ir_ld = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                dec_d        = dec_live;
                ctl.alu_func = dec_live.alu_func;
                ctl.imm_ext  = dec_live.imm_ext;
                ctl.bin_sel  = dec_live.cls inside {C_IMM, C_LOAD, C_STORE};
                ctl.rfb_sel  = dec_live.cls inside {C_STORE, C_BR};
                case (dec_live.cls)
                    C_R:            state_d = S_EXEC_R;
                    C_IMM:          state_d = S_EXEC_I;
                    C_LOAD, C_STORE: state_d = S_ADDR;
                    C_BR:           state_d = S_BR;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        ctl.pc_ld = 1'b1;
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_func = dec_q.alu_func;
                state_d      = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctl.alu_func = dec_q.alu_func;
                ctl.imm_ext  = dec_q.imm_ext;
                ctl.bin_sel  = 1'b1;
                state_d      = S_WB_ALU;
            end
            S_WB_ALU: begin
                ctl.rf_wr = 1'b1;
                ctl.pc_ld = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                ctl.alu_func = ALU_ADD;
                ctl.bin_sel  = 1'b1;
                state_d      = (dec_q.cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                ctl.mem_rd  = (state_q == S_MEM_RD);
                ctl.mem_wr  = (state_q == S_MEM_WR);
                ctl.byte_op = dec_q.byte_op;
                // Ready takes priority over a timeout landing in the same cycle.
                if (ctrl.Mem_Ready) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_WB_MEM: begin
                ctl.rf_wr  = 1'b1;
                ctl.rf_wds = 1'b1;
                ctl.pc_ld  = 1'b1;
                state_d    = S_FETCH;
            end
            S_NEXT: begin
                ctl.pc_ld = 1'b1;
                state_d   = S_FETCH;
            end
            S_BR: begin
                ctl.alu_func = ALU_SUB;
                ctl.rfb_sel  = 1'b1;
                ctl.imm_ext  = 2'b11;
                ctl.pc_ld    = 1'b1;
                case (dec_q.br_kind)
                    BK_B:    ctl.pc_sel = 1'b1;
                    BK_BEQ:  ctl.pc_sel = ctrl.ALU_Zero;
                    default: ctl.pc_sel = ~ctrl.ALU_Zero;
                endcase
                state_d = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
            end
`endif
            default: state_d = S_RST;
        endcase
        // Reset kills the current cycle's enables so an aborted instruction never writes.
        if (Reset) begin
            ctl = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal = 1'b0;
`endif
        end
    end

    assign ctrl.IR_LdEn       = ctl.ir_ld;
    assign ctrl.PC_LdEn       = ctl.pc_ld;
    assign ctrl.PC_sel        = ctl.pc_sel;
    assign ctrl.RF_WrEn       = ctl.rf_wr;
    assign ctrl.RF_WrData_sel = ctl.rf_wds;
    assign ctrl.RF_B_sel      = ctl.rfb_sel;
    assign ctrl.ImmExt        = ctl.imm_ext;
    assign ctrl.ALU_Bin_Sel   = ctl.bin_sel;
    assign ctrl.ALU_func      = ctl.alu_func;
    assign ctrl.Mem_Rd        = ctl.mem_rd;
    assign ctrl.Mem_WrEn      = ctl.mem_wr;
    assign ctrl.ByteOp        = ctl.byte_op;
    assign ctrl.Busy          = ctl.busy;
    assign ctrl.Mem_Err       = err_q & ~Reset;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign ctrl.Illegal       = illegal;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: per-instruction expected output sequences are built from the opcode rules and compared every cycle.
module tb_multicycle_ctrl;
    localparam int TMO = 15;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .ctrl  (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ir, pc_ld, pc_sel, rf_wr, rf_wds, rfb;
        logic [1:0] imm;
        logic       bin;
        logic [3:0] alu;
        logic       mrd, mwr, bop, err, busy;
    } ov_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero, rdy, rst;
        ov_t        exp;
    } cyc_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;
    bit   err_m    = 1'b0;
    cyc_t q[$];

    logic [5:0] legal_ops [16] = '{6'b100000, 6'b110000, 6'b110010, 6'b110011,
                                   6'b111000, 6'b111001, 6'b000011, 6'b001111,
                                   6'b000111, 6'b011111, 6'b010000, 6'b010001,
                                   6'b111111, 6'b100000, 6'b001111, 6'b011111};

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // 0 R, 1 immediate, 2 load, 3 store, 4 branch, 5 illegal
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'b100000:                                         return 0;
            6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001: return 1;
            6'b000011, 6'b001111:                              return 2;
            6'b000111, 6'b011111:                              return 3;
            6'b010000, 6'b010001, 6'b111111:                   return 4;
            default:                                           return 5;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b100000) return fn[3:0];
        if (op == 6'b110010) return 4'b0010;
        if (op == 6'b110011) return 4'b0011;
        if (cls_of(op) == 4) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [1:0] imm_of(input logic [5:0] op);
        if (op == 6'b110010 || op == 6'b110011) return 2'b01;
        if (op == 6'b111001) return 2'b10;
        if (cls_of(op) == 4) return 2'b11;
        return 2'b00;
    endfunction

    task automatic push(input ov_t e, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic r);
        cyc_t c;
        e.err = err_m;
        c.op = op; c.fn = fn; c.zero = z; c.rdy = r; c.rst = 1'b0; c.exp = e;
        q.push_back(c);
    endtask

    task automatic push_rst();
        cyc_t c;
        c.op = r6(); c.fn = r6(); c.zero = rb(); c.rdy = rb(); c.rst = 1'b1; c.exp = '0;
        q.push_back(c);
    endtask

    task automatic tail(input ov_t e, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic r, input bit rst_last);
        if (rst_last) begin
            push_rst();
            err_m = 1'b0;
            push(ov_t'('0), r6(), r6(), rb(), rb());
        end else begin
            push(e, op, fn, z, r);
        end
    endtask

    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int rdy_at, input bit rst_last);
        int  cls;
        bit  timed;
        ov_t e;
        cls = cls_of(op);
        e = '0; e.ir = 1'b1;
        push(e, r6(), r6(), rb(), rb());
        e = '0; e.busy = 1'b1; e.alu = alu_of(op, fn); e.imm = imm_of(op);
        e.bin = (cls inside {1, 2, 3}); e.rfb = (cls == 3 || cls == 4);
        if (cls == 5) begin
            e.pc_ld = 1'b1;
            tail(e, op, fn, rb(), rb(), rst_last);
            return;
        end
        push(e, op, fn, rb(), rb());
        if (cls <= 1) begin
            e = '0; e.busy = 1'b1; e.alu = alu_of(op, fn);
            if (cls == 1) begin e.bin = 1'b1; e.imm = imm_of(op); end
            push(e, r6(), r6(), rb(), rb());
            e = '0; e.busy = 1'b1; e.rf_wr = 1'b1; e.pc_ld = 1'b1;
            tail(e, r6(), r6(), rb(), rb(), rst_last);
        end else if (cls <= 3) begin
            e = '0; e.busy = 1'b1; e.bin = 1'b1;
            push(e, r6(), r6(), rb(), rb());
            timed = 1'b0;
            for (int k = 1; k <= TMO; k++) begin
                e = '0; e.busy = 1'b1; e.mrd = (cls == 2); e.mwr = (cls == 3);
                e.bop = (op == 6'b000011 || op == 6'b000111);
                push(e, r6(), r6(), rb(), (k == rdy_at));
                if (k == rdy_at) break;
                if (k == TMO) timed = 1'b1;
            end
            if (timed) err_m = 1'b1;
            e = '0; e.busy = 1'b1; e.pc_ld = 1'b1;
            if (cls == 2 && !timed) begin e.rf_wr = 1'b1; e.rf_wds = 1'b1; end
            tail(e, r6(), r6(), rb(), 1'b0, rst_last);
        end else begin
            e = '0; e.busy = 1'b1; e.alu = 4'b0001; e.rfb = 1'b1; e.imm = 2'b11; e.pc_ld = 1'b1;
            e.pc_sel = (op == 6'b111111) ? 1'b1 : (op == 6'b010000) ? zero : ~zero;
            tail(e, r6(), r6(), zero, rb(), rst_last);
        end
    endtask

    function automatic ov_t sample();
        ov_t a;
        a.ir = bus.IR_LdEn; a.pc_ld = bus.PC_LdEn; a.pc_sel = bus.PC_sel;
        a.rf_wr = bus.RF_WrEn; a.rf_wds = bus.RF_WrData_sel; a.rfb = bus.RF_B_sel;
        a.imm = bus.ImmExt; a.bin = bus.ALU_Bin_Sel; a.alu = bus.ALU_func;
        a.mrd = bus.Mem_Rd; a.mwr = bus.Mem_WrEn; a.bop = bus.ByteOp;
        a.err = bus.Mem_Err; a.busy = bus.Busy;
        return a;
    endfunction

    task automatic pin(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic run_queue();
        cyc_t c;
        ov_t  a;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; bus.Instr_op = c.op; bus.Instr_func = c.fn;
            bus.ALU_Zero = c.zero; bus.Mem_Ready = c.rdy;
            #1;
            cyc_n++;
            a = sample();
            checks++;
            if (a !== c.exp) begin
                failures++;
                $display("FAIL cycle %0d outputs: got %05h required %05h", cyc_n, a, c.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.Instr_op = '0; bus.Instr_func = '0; bus.ALU_Zero = 1'b0; bus.Mem_Ready = 1'b0;
        push_rst(); push_rst();
        push(ov_t'('0), r6(), r6(), rb(), rb());

        n0 = q.size(); add_instr(6'b100000, 6'b110000, 1'b0, 0, 1'b0); pin("len_radd", q.size() - n0, 4);
        add_instr(6'b100000, 6'b000001, 1'b0, 0, 1'b0);
        n0 = q.size(); add_instr(6'b001111, 6'b000000, 1'b0, 3, 1'b0); pin("len_lw_rdy3", q.size() - n0, 7);
        pin("err_after_lw", int'(err_m), 0);
        n0 = q.size(); add_instr(6'b011111, 6'b000000, 1'b0, 0, 1'b0); pin("len_sw_timeout", q.size() - n0, 19);
        pin("err_after_sw", int'(err_m), 1);
        add_instr(6'b110000, r6(), 1'b0, 0, 1'b0);
        n0 = q.size(); add_instr(6'b010000, r6(), 1'b1, 0, 1'b0); pin("len_beq", q.size() - n0, 3);
        pin("beq_z1_pcsel", int'(q[q.size() - 1].exp.pc_sel), 1);
        add_instr(6'b010001, r6(), 1'b1, 0, 1'b0);
        pin("bne_z1_pcsel", int'(q[q.size() - 1].exp.pc_sel), 0);
        add_instr(6'b111111, r6(), 1'b0, 0, 1'b0);
        add_instr(6'b010001, r6(), 1'b0, 0, 1'b0);
        add_instr(6'b100000, 6'b000010, 1'b0, 0, 1'b1);
        pin("err_after_reset", int'(err_m), 0);
        add_instr(6'b000011, r6(), 1'b0, TMO, 1'b0);
        pin("err_ready_at_timeout", int'(err_m), 0);
        add_instr(6'b000111, r6(), 1'b0, 1, 1'b0);
        n0 = q.size(); add_instr(6'b101010, r6(), 1'b0, 0, 1'b0); pin("len_illegal", q.size() - n0, 2);
        add_instr(6'b110011, r6(), 1'b0, 0, 1'b0);
        add_instr(6'b111001, r6(), 1'b0, 0, 1'b0);
        run_queue();

        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? r6() : legal_ops[$urandom_range(0, 15)];
            add_instr(op, r6(), rb(), int'($urandom_range(0, 17)), ($urandom_range(0, 9) == 0));
            run_queue();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
